// File: rtl/booth_datapath.sv
// Booth multiplier register datapath: M, A (with guard bit), Q, Q[-1], add/sub unit
// and a saturating shift counter, all driven by strobes from the control FSM.
module booth_datapath #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [WIDTH-1:0]               multiplier_in,
   input  logic [WIDTH-1:0]               multiplicand_in,
   input  logic                           q1,
   input  logic                           q2,
   input  logic                           a1,
   input  logic                           a2,
   input  logic                           m1,
   input  logic                           alu1,
   output logic                           c1,
   output logic                           c2,
   output logic [2*WIDTH-1:0]             product,
   output logic [$clog2(WIDTH+1)-1:0]     shift_count,
   output logic                           product_valid
);

   localparam int unsigned CW = $clog2(WIDTH+1);

   logic [WIDTH-1:0] r_m;
   logic [WIDTH:0]   r_a;      // extra guard bit keeps A-M from overflowing
   logic [WIDTH-1:0] r_q;
   logic             r_qm1;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH:0]   w_m_ext;
   logic [WIDTH:0]   w_alu;

   // Add/subtract of sign-extended M against the guarded accumulator
   always_comb begin
      w_m_ext = {r_m[WIDTH-1], r_m};
      w_alu   = alu1 ? (r_a - w_m_ext) : (r_a + w_m_ext);
   end

   // Multiplicand register: loads on m1, otherwise holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m <= '0;
      end else if (m1) begin
         r_m <= multiplicand_in;
      end
   end

   // Accumulator: hold / load ALU / arithmetic shift right / clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a <= '0;
      end else begin
         unique case ({a1, a2})
            2'b01:   r_a <= w_alu;
            2'b10:   r_a <= {r_a[WIDTH], r_a[WIDTH:1]};
            2'b11:   r_a <= '0;
            default: r_a <= r_a;
         endcase
      end
   end

   // Multiplier, Q[-1] and shift counter; a Q load restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q   <= '0;
         r_qm1 <= 1'b0;
         r_cnt <= '0;
      end else begin
         unique case ({q1, q2})
            2'b01: begin
               r_q   <= multiplier_in;
               r_qm1 <= 1'b0;
               r_cnt <= '0;
            end
            2'b10: begin
               // Pre-edge A[0] shifts in, even if A loads on the same edge
               r_q   <= {r_a[0], r_q[WIDTH-1:1]};
               r_qm1 <= r_q[0];
               if (r_cnt != CW'(WIDTH)) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_q   <= r_q;
               r_qm1 <= r_qm1;
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   // Outputs decode registered state only
   always_comb begin
      c1            = r_q[0];
      c2            = r_qm1;
      product       = {r_a[WIDTH-1:0], r_q};
      shift_count   = r_cnt;
      product_valid = (r_cnt == CW'(WIDTH));
   end

endmodule
